// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing controller: FSM encoding and default widths.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int DEF_W  = 8;
    localparam int DEF_PW = 2 * DEF_W;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_share_rr_arb.sv
// Combinational grant logic: round-robin from ptr_i+1, or fixed lowest-index priority
// when MULT_SHARE_FIXED_PRIO_EN is defined (the pointer input then disappears).
module mult_share_rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
`ifndef MULT_SHARE_FIXED_PRIO_EN
    input  logic [IDW-1:0]  ptr_i,
`endif
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        int j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        any_o   = |req_i;
`ifdef MULT_SHARE_FIXED_PRIO_EN
        // Scan downward so the lowest set index is the last one written.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDW'(i);
            end
        end
`else
        // Scan the farthest offset first so the nearest requester after ptr wins.
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (req_i[j]) begin
                idx_o = IDW'(j);
            end
        end
`endif
        if (any_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one registered multiplier among NREQ valid/ready requesters, one operation in flight.
// Build option MULT_SHARE_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = DEF_W,
    parameter int IDW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*W-1:0]    rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    output logic              mul_en_a,
    output logic              mul_en_b,
    input  logic [2*W-1:0]    mul_p,
    output logic              busy
);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, b_q;
    logic [IDW-1:0]  id_q;
    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_idx;
    logic            arb_any;
    logic            accept;

`ifndef MULT_SHARE_FIXED_PRIO_EN
    logic [IDW-1:0]  ptr_q;
`endif

    mult_share_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (req_valid),
`ifndef MULT_SHARE_FIXED_PRIO_EN
        .ptr_i   (ptr_q),
`endif
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // A grant during a reset cycle would be discarded, so it is never offered.
    assign accept = (state_q == IDLE) && arb_any && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
`ifndef MULT_SHARE_FIXED_PRIO_EN
            ptr_q   <= IDW'(NREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q  <= req_a[int'(arb_idx)*W +: W];
                b_q  <= req_b[int'(arb_idx)*W +: W];
                id_q <= arb_idx;
`ifndef MULT_SHARE_FIXED_PRIO_EN
                ptr_q <= arb_idx;
`endif
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_id    = '0;
        mul_en_a  = 1'b0;
        mul_en_b  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready = arb_grant;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                mul_en_a = 1'b1;
                mul_en_b = 1'b1;
                state_d  = MUL;
            end
            MUL: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = mul_p;
                rsp_id    = id_q;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand buses follow the captured operands; the enables alone qualify them.
    assign mul_a = a_q;
    assign mul_b = b_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Shares one registered 8x8 multiplier (operand registers with per-operand load enables, registered 16-bit product) among NREQ requesters.
- Each requester uses a valid/ready request channel; the block returns the product on a shared response channel tagged with the requester index.
- Arbitration is round-robin. One operation is in flight at a time.
- Sits between requester logic and the multiplier instance; drives the multiplier's operand buses and load enables, and reads its product.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 8, operand width; product width is 2*W.
- IDW, 1, response tag width; must equal clog2(NREQ), minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*W  packed operand A; slice i belongs to requester i.
- req_b  in  NREQ*W  packed operand B.
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accepts product.
- rsp_data  out  2*W  product.
- rsp_id  out  IDW  index of the requester that owns the product.
- mul_a  out  W  to multiplier operand A input.
- mul_b  out  W  to multiplier operand B input.
- mul_en_a  out  1  to multiplier operand A load enable.
- mul_en_b  out  1  to multiplier operand B load enable.
- mul_p  in  2*W  from multiplier registered product.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (rst sampled high at a clk edge): state=IDLE; req_ready=0; rsp_valid=0; rsp_data=0; rsp_id=0; mul_a=0; mul_b=0; mul_en_a=0; mul_en_b=0; busy=0; rr pointer=NREQ-1, so requester 0 wins first.
- The multiplier shares rst. Reset mid-operation abandons the operation: no response is produced and no requester is re-served.
- FSM state IDLE:
  - If any req_valid is high, the winner is the first requester with valid set, searching from pointer+1 with wrap-around.
  - req_ready[winner] is asserted combinationally in the same cycle; the handshake completes that cycle.
  - Captured into internal registers: req_a/req_b slice of the winner and its id. Pointer is set to the winner. Next state is LOAD.
  - If no req_valid is high, stay in IDLE.
- LOAD: mul_a/mul_b = captured operands; mul_en_a=mul_en_b=1. Multiplier operand registers load at the end of this cycle. Next state is MUL.
- MUL: enables low. Multiplier product register loads at the end of this cycle. Next state is RESP.
- RESP:
  - rsp_valid=1, rsp_data=mul_p, rsp_id=captured id.
  - Values stay stable until rsp_ready is high; holding is safe because the operands do not change.
  - When rsp_valid and rsp_ready are both high, go to IDLE.
- Latency and throughput:
  - Request accepted in cycle T; rsp_valid rises in cycle T+3.
  - With rsp_ready held high, the next accept occurs at T+4, giving 1 operation per 4 cycles.
- req_ready is 0 in every state except IDLE.
- Requests arriving while busy wait; requesters must hold valid and operands stable until ready.
- Product is unsigned, 2*W bits, no truncation.
  - 255*255=65025 (0xFE01); 0*x=0.
- mul_a/mul_b hold their last value outside LOAD; only the enables qualify them.
- Simultaneous requests resolve by round-robin. The pointer advances only on a grant, so no requester is starved.

Optional Feature:
- Macro MULT_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index requester with valid set always wins, and the pointer register is removed.
- Undefined (default): round-robin as above.

Decomposition:
- Package mult_share_pkg holds:
  - FSM state encoding: IDLE=2'd0, LOAD=2'd1, MUL=2'd2, RESP=2'd3.
  - Default W=8 and product width constant.
- One sub-module, mult_share_rr_arb: inputs req vector and pointer; output one-hot grant and encoded index.
  - Combinational grant; the pointer register stays in the parent.
  - The fixed-priority variant lives inside this sub-module under the macro.

Test Plan:
- Reset then single request: req_valid=01, a=12, b=10 → req_ready=01 in the same cycle; rsp_valid at +3 cycles with rsp_data=120 and rsp_id=0; busy high from +1 until the response handshake.
- Corner values: a=255, b=255 → rsp_data=0xFE01. a=0, b=200 → rsp_data=0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_data and rsp_id stable; req_ready stays 0 for a pending req1; req1 is accepted the cycle after the rsp handshake.
- Contention: both requesters continuously valid (r0 3*4, r1 5*6), rsp_ready=1 → grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; data 12,30,12,30; accepts spaced exactly 4 cycles apart.
- Reset mid-op: assert rst during MUL → next cycle rsp_valid=0, busy=0, no response for the aborted request; after release with req1 valid, r0 wins first if also valid.
- With MULT_SHARE_FIXED_PRIO_EN defined, repeating the contention test → requester 0 is granted every time; requester 1 is never granted while r0 is valid.
